// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button increment front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_DELAY_DEF    = 64;
    localparam int REPEAT_PERIOD_DEF   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_incr_pulser_sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_incr_pulser.sv
// Synchronises, debounces and edge-detects a raw push-button into one incr pulse per press.
// Optional auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_incr_pulser
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic incr,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_params
        $error("btn_incr_pulser: illegal parameter value");
    end

    logic       s;
    btn_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       incr_q, incr_d;
    logic       btn_level_q, btn_level_d;
    logic       press_pulse;
    logic       rpt_pulse;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A re-bounce returns to HELD silently so a release never double-counts.
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic [TW-1:0] hold_tmr_q, hold_tmr_d;
    logic          rpt_phase_q, rpt_phase_d;

    // Timer only runs while staying in HELD; entry and exit both restart the first phase.
    always_comb begin
        hold_tmr_d  = '0;
        rpt_phase_d = 1'b0;
        rpt_pulse   = 1'b0;
        if (state_q == HELD && state_d == HELD) begin
            if (hold_tmr_q == (rpt_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
                rpt_pulse   = 1'b1;
                rpt_phase_d = 1'b1;
            end else begin
                hold_tmr_d  = hold_tmr_q + TW'(1);
                rpt_phase_d = rpt_phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_tmr_q  <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            hold_tmr_q  <= hold_tmr_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
        incr_d      = press_pulse | rpt_pulse;
        btn_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            incr_q      <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            incr_q      <= incr_d;
            btn_level_q <= btn_level_d;
        end
    end

    assign incr      = incr_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_btn_incr_pulser.sv
// Directed bench for btn_incr_pulser with N=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_btn_incr_pulser;
    import btn_pkg::*;

    localparam int N   = 4;
    localparam int RD  = 8;
    localparam int RP  = 4;
    localparam int LAT = N + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic incr;
    logic btn_level;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  cnt8 = 8'd0;
    logic        prev_incr = 1'b0;

    btn_incr_pulser #(
        .DEBOUNCE_CYCLES (N),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .incr      (incr),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pulse(input int offset);
        exp_q.push_back(32'(edge_cnt + offset));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every incr pulse must match the next expected edge number.
    always @(negedge clk) begin
        logic [31:0] exp_e;
        if (incr === 1'b1) begin
            cnt8 = cnt8 + 8'd1;
            checks++;
            assert (!prev_incr) else begin
                errors++;
                $error("FAIL incr_back_to_back observed_edge=%0d expected=single_cycle", edge_cnt);
            end
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL incr_unexpected observed_edge=%0d expected=no_pulse", edge_cnt);
            end
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                checks++;
                assert (32'(edge_cnt) === exp_e) else begin
                    errors++;
                    $error("FAIL incr_edge observed=%0d expected=%0d", edge_cnt, exp_e);
                end
            end
        end
        prev_incr = (incr === 1'b1);
    end

    initial begin
        int k;
        int last_hi;
        logic [7:0] base;

        rst_n  = 1'b0;
        btn_in = 1'b0;
        step(3);
        check("reset_incr", 32'(incr), 32'd0);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst_n = 1'b1;
        step(3);

        // 1: clean press held 20 cycles
        base   = cnt8;
        btn_in = 1'b1;
        k      = edge_cnt;
        push_pulse(LAT);
`ifdef BTN_AUTO_REPEAT_EN
        push_pulse(LAT + RD);
        push_pulse(LAT + RD + RP);
        push_pulse(LAT + RD + 2 * RP);
`endif
        step(LAT - 1);
        check("t1_level_before", 32'(btn_level), 32'd0);
        step(1);
        check("t1_incr_at_edge6", 32'(incr), 32'd1);
        check("t1_level_at_edge6", 32'(btn_level), 32'd1);
        step(20 - LAT);
        btn_in = 1'b0;
        step(12);
`ifdef BTN_AUTO_REPEAT_EN
        check("t1_counter", 32'(cnt8 - base), 32'd4);
`else
        check("t1_counter", 32'(cnt8 - base), 32'd1);
`endif

        // 2: bounce on press
        btn_in = 1'b1; step(1);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; step(1);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1;
        push_pulse(LAT);
        step(10);
        check("t2_level_held", 32'(btn_level), 32'd1);
        btn_in = 1'b0;
        step(10);
        check("t2_level_released", 32'(btn_level), 32'd0);

        // 3: short glitch, then press with release re-bounce
        btn_in = 1'b1; step(3);
        btn_in = 1'b0; step(8);
        check("t3_glitch_level", 32'(btn_level), 32'd0);
        check("t3_glitch_state", 32'(dut.state_q), 32'(IDLE));
        btn_in = 1'b1;
        push_pulse(LAT);
        step(10);
        btn_in = 1'b0; step(2);
        btn_in = 1'b1; step(2);
        btn_in  = 1'b0;
        last_hi = edge_cnt;
        step(LAT - 1);
        check("t3_level_rel_wait", 32'(btn_level), 32'd1);
        check("t3_state_rel_wait", 32'(dut.state_q), 32'(RELEASE_WAIT));
        step(1);
        check("t3_idle_edge", 32'(edge_cnt - last_hi), 32'(LAT));
        check("t3_level_idle", 32'(btn_level), 32'd0);
        check("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
        step(4);

        // 4: reset during PRESS_WAIT and during the incr cycle
        btn_in = 1'b1;
        step(4);
        check("t4_state_pw", 32'(dut.state_q), 32'(PRESS_WAIT));
        check("t4_cnt_pw", 32'(dut.cnt_q), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t4_rst1_incr", 32'(incr), 32'd0);
        check("t4_rst1_level", 32'(btn_level), 32'd0);
        check("t4_rst1_state", 32'(dut.state_q), 32'(IDLE));
        step(2);
        rst_n = 1'b1;
        step(LAT);
        check("t4_pulse_before_rst", 32'(incr), 32'd1);
        check("t4_level_before_rst", 32'(btn_level), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_rst2_incr", 32'(incr), 32'd0);
        check("t4_rst2_level", 32'(btn_level), 32'd0);
        step(2);
        rst_n = 1'b1;
        push_pulse(LAT);
        step(10);
        check("t4_level_after", 32'(btn_level), 32'd1);
        btn_in = 1'b0;
        step(10);

        // 5: long hold (auto-repeat when enabled)
        btn_in = 1'b1;
        push_pulse(LAT);
`ifdef BTN_AUTO_REPEAT_EN
        for (int i = 0; i < 6; i++) push_pulse(LAT + RD + i * RP);
`endif
        step(LAT + 28);
        btn_in = 1'b0;
        step(10);
        check("t5_level_released", 32'(btn_level), 32'd0);

        // 6: ten clean presses
        base = cnt8;
        for (int i = 0; i < 10; i++) begin
            btn_in = 1'b1;
            push_pulse(LAT);
            step(10);
            btn_in = 1'b0;
            step(10);
        end
        step(2);
        check("t6_counter", 32'(cnt8 - base), 32'h0A);
        check("pending_pulses", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
